round_key_store: RTL

ROUND_KEY_STORE -- requirements
Module: round_key_store

---
 rtl/round_key_store_if.sv | 27 ++
 rtl/round_key_store.sv | 95 +++++++++
 2 files changed

// File: rtl/round_key_store_if.sv
// Bus bundle for round_key_store: load control, subkey capture, read port, status.
interface round_key_store_if;
  logic         load_start;
  logic [1:0]   key_len;
  logic [127:0] subkey_in;
  logic         subkey_vld;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic         rd_rev;
  logic [127:0] rd_key;
  logic         rd_vld;
  logic         keys_ready;
  logic         busy;
  logic         err;

  modport master (
    output load_start, key_len, subkey_in, subkey_vld,
    output rd_en, rd_idx, rd_rev,
    input  rd_key, rd_vld, keys_ready, busy, err
  );

  modport slave (
    input  load_start, key_len, subkey_in, subkey_vld,
    input  rd_en, rd_idx, rd_rev,
    output rd_key, rd_vld, keys_ready, busy, err
  );
endinterface

// File: rtl/round_key_store.sv
// AES round-key store: captures 11/13/15 expanded keys, then serves
// registered reads in forward or reverse (decryption) order.
module round_key_store (
  input  logic              clk,
  input  logic              reset,
  round_key_store_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [3:0]   wr_ptr_q, wr_ptr_d;
  logic [3:0]   nkeys_q, nkeys_d;
  logic         err_q, err_d;
  logic         rd_vld_q, rd_vld_d;
  logic [127:0] rd_key_q, rd_key_d;
  logic [127:0] mem_q [15];
  logic         wr_en;
  logic [3:0]   last_idx;
  logic [3:0]   eff_idx;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    nkeys_d  = nkeys_q;
    err_d    = err_q;
    rd_vld_d = 1'b0;
    rd_key_d = '0;
    wr_en    = 1'b0;
    last_idx = nkeys_q - 4'd1;
    eff_idx  = bus.rd_rev ? (last_idx - bus.rd_idx)
                          : bus.rd_idx;
    if (bus.load_start) begin
      state_d  = S_FILL;
      wr_ptr_d = 4'd0;
      err_d    = 1'b0;
      unique case (1'b1)
        (bus.key_len == 2'd1): nkeys_d = 4'd13;
        (bus.key_len == 2'd2): nkeys_d = 4'd15;
        default:               nkeys_d = 4'd11;
      endcase
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (bus.subkey_vld) begin
            wr_en = 1'b1;
            // pointer parks on the last entry once full
            if (wr_ptr_q == last_idx) state_d = S_READY;
            else wr_ptr_d = wr_ptr_q + 4'd1;
          end
        end
        S_READY: begin
          if (bus.subkey_vld) err_d = 1'b1;
          if (bus.rd_en) begin
            rd_vld_d = 1'b1;
            if (bus.rd_idx < nkeys_q) rd_key_d = mem_q[eff_idx];
            else err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= 4'd0;
      nkeys_q  <= 4'd11;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_key_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      nkeys_q  <= nkeys_d;
      err_q    <= err_d;
      rd_vld_q <= rd_vld_d;
      rd_key_q <= rd_key_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.subkey_in;
  end

  assign bus.rd_key     = rd_key_q;
  assign bus.rd_vld     = rd_vld_q;
  assign bus.keys_ready = (state_q == S_READY);
  assign bus.busy       = (state_q == S_FILL);
  assign bus.err        = err_q;

endmodule
